mux2_rr_arbiter: RTL and testbench

//   Shares one 2-to-1 selector output channel between two valid/ready requesters.

---
 rtl/mux2_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a 2:1 word selector.
// The owner keeps the grant for up to MAX_BURST transfers while the other side waits.
module mux2_rr_arbiter #(
  parameter int DATA_LEN  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [DATA_LEN-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [DATA_LEN-1:0] req1_data,
  output logic                req1_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  input  logic                out_ready,
  output logic                sel,
  output logic                busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             sel_next;
  logic             last;
  logic             last_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic grant0;
  logic grant1;
  logic owner;
  logic own_valid;
  logic other_valid;
  logic xfer;
  logic cnt_at_last;
  logic do_release;

  assign grant0 = (state == ST_GRANT0);
  assign grant1 = (state == ST_GRANT1);
  assign busy   = grant0 | grant1;

  // owner is only meaningful while busy; it names the side holding the grant.
  assign owner       = grant1;
  assign own_valid   = owner ? req1_valid : req0_valid;
  assign other_valid = owner ? req0_valid : req1_valid;

  assign out_valid  = (grant0 & req0_valid) | (grant1 & req1_valid);
  assign req0_ready = grant0 & out_ready;
  assign req1_ready = grant1 & out_ready;
  assign xfer       = out_valid & out_ready;

  // The data path is forced low during reset so every output reads 0.
  assign out_data = rst_n ? (sel ? req1_data : req0_data) : '0;

  assign cnt_at_last = (cnt == CNT_W'(MAX_BURST - 1));

  // A grant ends when its owner stops offering words, or when the burst
  // budget is spent and the other side is waiting.
  assign do_release = busy & (~own_valid | (xfer & cnt_at_last & other_valid));

  always_comb begin
    state_next = state;
    sel_next   = sel;
    last_next  = last;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          state_next = last ? ST_GRANT0 : ST_GRANT1;
          sel_next   = ~last;
        end else if (req0_valid) begin
          state_next = ST_GRANT0;
          sel_next   = 1'b0;
        end else if (req1_valid) begin
          state_next = ST_GRANT1;
          sel_next   = 1'b1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (do_release) begin
          last_next = owner;
          cnt_next  = '0;
          if (other_valid) begin
            // Hand straight over to the waiting side with no idle bubble.
            state_next = owner ? ST_GRANT0 : ST_GRANT1;
            sel_next   = ~owner;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (xfer) begin
          cnt_next = cnt_at_last ? '0 : cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      last  <= last_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed vector table, hand-written corner sequences
// and random traffic compared against a grant/burst reference model.
module tb_mux2_rr_arbiter;

  localparam int DATA_LEN  = 1;
  localparam int MAX_BURST = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req0_valid = 1'b0;
  logic [DATA_LEN-1:0] req0_data = '0;
  logic                req0_ready;
  logic                req1_valid = 1'b0;
  logic [DATA_LEN-1:0] req1_data = '0;
  logic                req1_ready;
  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic                out_ready = 1'b0;
  logic                sel;
  logic                busy;

  mux2_rr_arbiter #(.DATA_LEN(DATA_LEN), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns the channel (-1 = nobody), who was served last,
  // how many words the current owner has moved, and the remembered select.
  int m_owner;
  int m_last;
  int m_cnt;
  int m_sel;
  int obs_xfer;

  typedef struct {
    logic v0, d0, v1, d1, rdy;
    logic e_valid, e_data, e_sel, e_r0, e_r1, e_busy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  task automatic model_update();
    int  n, o;
    bit  rel;
    bit  v[2];
    v[0] = req0_valid;
    v[1] = req1_valid;
    if (m_owner < 0) begin
      if (v[0] && v[1]) m_owner = 1 - m_last;
      else if (v[0])    m_owner = 0;
      else if (v[1])    m_owner = 1;
    end else begin
      n   = m_owner;
      o   = 1 - n;
      rel = 1'b0;
      if (!v[n]) rel = 1'b1;
      else if (out_ready) begin
        m_cnt++;
        if (m_cnt == MAX_BURST) begin
          if (v[o]) rel = 1'b1;
          else      m_cnt = 0;
        end
      end
      if (rel) begin
        m_last  = n;
        m_cnt   = 0;
        m_owner = v[o] ? o : -1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic check_model();
    logic e_valid, e_data;
    e_valid = (m_owner == 0 && req0_valid) || (m_owner == 1 && req1_valid);
    e_data  = (m_sel == 1) ? req1_data[0] : req0_data[0];
    chk("model out_valid", out_valid, e_valid);
    chk("model out_data", out_data, e_data);
    chk("model sel", sel, m_sel[0]);
    chk("model req0_ready", req0_ready, (m_owner == 0) && out_ready);
    chk("model req1_ready", req1_ready, (m_owner == 1) && out_ready);
    chk("model busy", busy, m_owner >= 0);
  endtask

  // One cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    check_model();
    obs_xfer = out_valid & out_ready;
    $display("cyc t=%0t v0=%b v1=%b rdy=%b -> valid=%b data=%b sel=%b r0=%b r1=%b busy=%b",
             $time, req0_valid, req1_valid, out_ready, out_valid, out_data, sel,
             req0_ready, req1_ready, busy);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v0, input logic d0, input logic v1, input logic d1, input logic rdy);
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; out_ready = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] in_bits, input logic [5:0] exp_bits);
    vec_t r;
    {r.v0, r.d0, r.v1, r.d1, r.rdy} = in_bits;
    {r.e_valid, r.e_data, r.e_sel, r.e_r0, r.e_r1, r.e_busy} = exp_bits;
    return r;
  endfunction

  initial begin
    int xfers;
    //                 v0 d0 v1 d1 rdy    valid data sel r0 r1 busy
    vecs[0] = mk(5'b1_0_1_1_1, 6'b0_0_0_0_0_0);
    for (int i = 1; i <= 4; i++) vecs[i] = mk(5'b1_0_1_1_1, 6'b1_0_0_1_0_1);
    for (int i = 5; i <= 8; i++) vecs[i] = mk(5'b1_0_1_1_1, 6'b1_1_1_0_1_1);
    vecs[9]  = mk(5'b1_0_1_1_1, 6'b1_0_0_1_0_1);
    vecs[10] = mk(5'b1_0_1_1_1, 6'b1_0_0_1_0_1);
    vecs[11] = mk(5'b1_0_1_1_0, 6'b1_0_0_0_0_1);
    vecs[12] = mk(5'b1_0_1_1_0, 6'b1_0_0_0_0_1);
    vecs[13] = mk(5'b1_0_1_1_1, 6'b1_0_0_1_0_1);
    vecs[14] = mk(5'b1_0_1_1_1, 6'b1_0_0_1_0_1);
    vecs[15] = mk(5'b1_0_1_1_1, 6'b1_1_1_0_1_1);

    // Reset asserted with both requesters offering words: everything reads 0.
    model_reset();
    drive(1, 1, 1, 1, 1);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset sel", sel, 0);
    chk("reset req0_ready", req0_ready, 0);
    chk("reset req1_ready", req1_ready, 0);
    chk("reset busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention with a backpressure window inside a grant-0 burst.
    drive(1, 0, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].rdy);
      #2;
      chk("vec out_valid", out_valid, vecs[i].e_valid);
      chk("vec out_data", out_data, vecs[i].e_data);
      chk("vec sel", sel, vecs[i].e_sel);
      chk("vec req0_ready", req0_ready, vecs[i].e_r0);
      chk("vec req1_ready", req1_ready, vecs[i].e_r1);
      chk("vec busy", busy, vecs[i].e_busy);
      step();
    end

    // Lone requester 1: nine transfers in ten cycles, grant never changes.
    do_reset();
    drive(0, 0, 1, 1, 1);
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      xfers += obs_xfer;
    end
    chk("single xfer count", xfers, 9);
    #2 chk("single sel", sel, 1);

    // Requester 0 drops valid after two transfers while requester 1 waits.
    do_reset();
    drive(1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 1, 1, 1);
    #2 chk("drop no out_valid", out_valid, 0);
    step();
    #2;
    chk("drop sel", sel, 1);
    chk("drop req1_ready", req1_ready, 1);
    chk("drop out_data", out_data, 1);
    for (int i = 0; i < 6; i++) step();

    // Reset pulse between clock edges in the middle of a burst.
    drive(1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async out_data", out_data, 0);
    chk("async busy", busy, 0);
    chk("async sel", sel, 0);
    chk("async req0_ready", req0_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Random traffic against the model, with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
